aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL expose parameter: none (all constants come from aes_pkg).
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  plaintext block offered.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 in_data  input  128  plaintext block.
REQ-007 mode  input  2  key size: 00=128, 01=192, 10=256, 11 treated as 256.
REQ-008 round  output  4  current round index to datapath and key schedule.
REQ-009 width_sel  output  2  current 32-bit word slot to datapath.
REQ-010 dp_data_in  output  128  state fed to the round datapath.
REQ-011 dp_data_out  input  128  round datapath result (combinational from dp_data_in, round, width_sel, round key).
REQ-012 out_valid  output  1  ciphertext available.
REQ-013 out_ready  input  1  consumer accepts ciphertext.
REQ-014 out_data  output  128  ciphertext block.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ARK0, ROUND, DONE.
REQ-017 IDLE: in_ready=1; on in_valid, state_reg<=in_data, mode_reg<=mode, round<=0, width_sel<=0, go to ARK0.
REQ-018 ARK0 (one cycle): state_reg<=dp_data_out, round<=1, width_sel<=0, go to ROUND.
REQ-019 ROUND: width_sel increments by 1 each cycle, wrapping 3->0.
REQ-020 ROUND, width_sel==3: state_reg<=dp_data_out; if round==Nr, go to DONE; else round<=round+1.
REQ-021 Nr is derived from mode_reg: 10, 12, 14 for 00, 01, {10,11}.
REQ-022 dp_data_in SHALL equal state_reg at all times, so it is stable across the four word cycles of a round.
REQ-023 DONE: out_valid=1, out_data=state_reg; on out_ready, go to IDLE; round and width_sel are held.
REQ-024 Latency: out_valid rises exactly 1+4*Nr cycles after the accepting edge (41/49/57).
REQ-025 in_ready SHALL be 0 outside IDLE; in_valid in those states is ignored (not queued).
REQ-026 A DONE->IDLE transition and a new in_valid SHALL NOT overlap; acceptance occurs no earlier than the cycle after the out handshake.
REQ-027 mode and in_data changes outside the accepting cycle SHALL have no effect.
REQ-028 out_valid SHALL remain high and out_data stable under out_ready=0 indefinitely.

Reset
REQ-029 reset_n low SHALL asynchronously force state=IDLE, state_reg=0, mode_reg=00, round=0, width_sel=0, out_valid=0, busy=0, in_ready=1 (once reset_n is high).
REQ-030 Reset mid-operation SHALL discard the in-flight block with no out_valid pulse.

Structure
REQ-031 aes_pkg SHALL hold the FSM state enum, mode encodings, and the NR_128/NR_192/NR_256 constants.
REQ-032 No sub-module; the controller is a single module, and aes_rounddata with the key schedule are instantiated alongside it at the top level.

Verification
REQ-033 Mode 00, in_data accepted at cycle 0 -> round 0 for 1 cycle, then rounds 1..10 each for 4 cycles with width_sel 0,1,2,3; out_valid at cycle 41.
REQ-034 Mode 11 -> identical to mode 10; last round is 14; out_valid at cycle 57.
REQ-035 out_ready held low 20 cycles after out_valid -> out_valid and out_data stable; in_ready=0 throughout; the block is accepted on the first cycle out_ready=1.
REQ-036 reset_n pulsed low mid-round 5 -> outputs immediately at reset values; the next block completes correctly.
REQ-037 Integrated with the datapath and key schedule, AES-128: key 000102...0f, plaintext 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-038 Integrated AES-256: key 000102...1f, same plaintext -> out_data 8ea2b7ca516745bfeafc49904b496089.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants for the AES round controller: FSM states, key-size modes
// and the round count for each key size.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARK0  = 2'b01,
    ROUND = 2'b10,
    DONE  = 2'b11
  } ctrl_state_e;

  typedef enum logic [1:0] {
    MODE_128     = 2'b00,
    MODE_192     = 2'b01,
    MODE_256     = 2'b10,
    MODE_256_ALT = 2'b11
  } key_mode_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // The reserved encoding 11 runs as a 256-bit key.
  function automatic logic [3:0] nr_of(input key_mode_e m);
    logic [3:0] nr;
    case (m)
      MODE_128: nr = NR_128;
      MODE_192: nr = NR_192;
      default:  nr = NR_256;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a plaintext block, steps the external round
// datapath through ARK0 and Nr four-word rounds, then holds the ciphertext.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   mode,
  output logic [3:0]   round,
  output logic [1:0]   width_sel,
  output logic [127:0] dp_data_in,
  input  logic [127:0] dp_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  ctrl_state_e  state, state_nxt;
  key_mode_e    mode_reg, mode_nxt;
  logic [127:0] state_reg, state_reg_nxt;
  logic [3:0]   round_nxt;
  logic [1:0]   width_sel_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode_reg  <= MODE_128;
      state_reg <= '0;
      round     <= '0;
      width_sel <= '0;
    end else begin
      state     <= state_nxt;
      mode_reg  <= mode_nxt;
      state_reg <= state_reg_nxt;
      round     <= round_nxt;
      width_sel <= width_sel_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_reg;
    state_reg_nxt = state_reg;
    round_nxt     = round;
    width_sel_nxt = width_sel;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_reg_nxt = in_data;
          mode_nxt      = key_mode_e'(mode);
          round_nxt     = '0;
          width_sel_nxt = '0;
          state_nxt     = ARK0;
        end
      end
      ARK0: begin
        state_reg_nxt = dp_data_out;
        round_nxt     = 4'd1;
        width_sel_nxt = '0;
        state_nxt     = ROUND;
      end
      ROUND: begin
        // width_sel wraps to 0 on the final word, so DONE holds round=Nr, width_sel=0.
        width_sel_nxt = width_sel + 2'd1;
        if (width_sel == 2'd3) begin
          state_reg_nxt = dp_data_out;
          if (round == nr_of(mode_reg)) begin
            state_nxt = DONE;
          end else begin
            round_nxt = round + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_data   = state_reg;
  assign dp_data_in = state_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with a stand-in round datapath and a ciphertext scoreboard.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   mode;
  logic [3:0]   round;
  logic [1:0]   width_sel;
  logic [127:0] dp_data_in;
  logic [127:0] dp_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .round      (round),
    .width_sel  (width_sel),
    .dp_data_in (dp_data_in),
    .dp_data_out(dp_data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // Stand-in datapath: depends on state, round and word slot so mis-timed captures show up.
  function automatic logic [127:0] dp_f(input logic [127:0] s, input logic [3:0] r, input logic [1:0] w);
    return ({s[119:0], s[127:120]} ^ {32{r}}) + {126'd0, w};
  endfunction

  function automatic int nr_m(input logic [1:0] md);
    return (md == 2'b00) ? 10 : (md == 2'b01) ? 12 : 14;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1:0] md);
    logic [127:0] s;
    s = dp_f(pt, 4'd0, 2'd0);
    for (int r = 1; r <= nr_m(md); r++) s = dp_f(s, 4'(r), 2'd3);
    return s;
  endfunction

  assign dp_data_out = dp_f(dp_data_in, round, width_sel);

  task automatic accept(input logic [127:0] pt, input logic [1:0] md);
    int w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = pt; mode = md;
    @(posedge clk);
    exp_q.push_back(enc(pt, md));
    #1;
    in_valid = 1'b0; in_data = {$urandom(), $urandom(), $urandom(), $urandom()}; mode = ~md;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || round !== 4'd0 || width_sel !== 2'd0) begin
      fails++;
      $display("FAIL accept: busy=%b in_ready=%b round=%0d ws=%0d required 1 0 0 0", busy, in_ready, round, width_sel);
    end
  endtask

  task automatic track(input logic [127:0] pt, input logic [1:0] md, input int hold,
                       input bit chain, input logic [127:0] npt, input logic [1:0] nmd);
    int nr = nr_m(md);
    logic [127:0] ms = pt;
    logic [127:0] od;
    logic [3:0] er;
    logic [1:0] ew;
    for (int j = 0; j <= 4 * nr; j++) begin
      er = (j == 0) ? 4'd0 : 4'((j - 1) / 4 + 1);
      ew = (j == 0) ? 2'd0 : 2'((j - 1) % 4);
      tests++;
      if (round !== er || width_sel !== ew || dp_data_in !== ms || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL seq j=%0d: round=%0d ws=%0d dp_in=%h ov=%b ir=%b busy=%b, required round=%0d ws=%0d dp_in=%h ov=0 ir=0 busy=1",
                 j, round, width_sel, dp_data_in, out_valid, in_ready, busy, er, ew, ms);
      end
      if (j == 0) ms = dp_f(ms, 4'd0, 2'd0);
      else if (ew == 2'd3) ms = dp_f(ms, er, 2'd3);
      // Noise on the input side while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mode     = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || round !== 4'(nr) || width_sel !== 2'd0 || out_data !== ms ||
        exp_q.size() == 0 || out_data !== exp_q[0]) begin
      fails++;
      $display("FAIL done: ov=%b round=%0d ws=%0d out=%h, required ov=1 round=%0d ws=0 out=%h",
               out_valid, round, width_sel, out_data, nr, ms);
    end
    od = out_data;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== od || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold h=%0d: ov=%b out=%h ir=%b, required ov=1 out=%h ir=0", h, out_valid, out_data, in_ready, od);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (chain) begin
      in_valid = 1'b1; in_data = npt; mode = nmd;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL handshake: ov=%b ir=%b busy=%b, required ov=0 ir=1 busy=0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'b00; out_ready = 1'b0;
    #3;
    tests++;
    if (round !== 4'd0 || width_sel !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1 || dp_data_in !== 128'd0 || out_data !== 128'd0) begin
      fails++;
      $display("FAIL reset: round=%0d ws=%0d ov=%b busy=%b ir=%b dp_in=%h, required 0 0 0 0 1 0",
               round, width_sel, out_valid, busy, in_ready, dp_data_in);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode(input logic [127:0] pt, input logic [1:0] md);
    accept(pt, md);
    track(pt, md, 0, 1'b0, '0, 2'b00);
  endtask

  task automatic test_backpressure_back_to_back();
    logic [127:0] p1 = 128'h0123456789abcdeffedcba9876543210;
    logic [127:0] p2 = 128'hdeadbeef00000000cafef00d11111111;
    accept(p1, 2'b01);
    track(p1, 2'b01, 20, 1'b1, p2, 2'b10);
    accept(p2, 2'b10);
    track(p2, 2'b10, 0, 1'b0, '0, 2'b00);
  endtask

  task automatic test_reset_mid();
    logic [127:0] p = 128'h55555555aaaaaaaa0f0f0f0ff0f0f0f0;
    int seen = 0;
    accept(p, 2'b00);
    for (int j = 0; j < 19; j++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (round !== 4'd5 || width_sel !== 2'd2) begin
      fails++; $display("FAIL pre_reset: round=%0d ws=%0d required 5 2", round, width_sel);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (round !== 4'd0 || width_sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        dp_data_in !== 128'd0 || out_data !== 128'd0) begin
      fails++;
      $display("FAIL reset_mid: round=%0d ws=%0d busy=%b ov=%b dp_in=%h, required 0 0 0 0 0",
               round, width_sel, busy, out_valid, dp_data_in);
    end
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_discard: active cycles=%0d ir=%b, required 0 and 1", seen, in_ready);
    end
    test_mode(128'h00112233445566778899aabbccddeeff, 2'b00);
  endtask

  initial begin
    test_reset();
    test_mode(128'h00112233445566778899aabbccddeeff, 2'b00);
    test_mode(128'h00112233445566778899aabbccddeeff, 2'b01);
    test_mode(128'h00112233445566778899aabbccddeeff, 2'b10);
    test_mode(128'h00112233445566778899aabbccddeeff, 2'b11);
    test_mode(128'hffffffffffffffffffffffffffffffff, 2'b11);
    test_backpressure_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
